// File: rtl/neosd_clk_div.sv
// SD card clock generator with a programmable half-period divider.
// Requests and stalls from any number of CMD/DATA FSMs are merged. The low phase is stretched
// on stall, a started high phase always runs to completion, and a burst of N clocks can be
// emitted without any request (card init). The rise/fall strobes are registered and line up
// with the sd_clk_o edges.
module neosd_clk_div #(
  parameter int unsigned DIV_W   = 10,
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned N_STALL = 2,
  parameter int unsigned BURST_W = 8
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [DIV_W-1:0]   div_i,
  input  logic [N_REQ-1:0]   sd_clk_req_i,
  input  logic [N_STALL-1:0] sd_clk_stall_i,
  input  logic               burst_start_i,
  input  logic [BURST_W-1:0] burst_len_i,
  output logic               burst_busy_o,
  output logic               sd_clk_en_o,
  output logic               rise_strb_o,
  output logic               fall_strb_o,
  output logic               sd_clk_o
);

  typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               sd_clk_q, sd_clk_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic               busy_q, busy_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

  logic go, stall, run, terminal;

  // A running burst keeps the clock requested on its own.
  assign go       = (|sd_clk_req_i) | busy_q;
  assign stall    = |sd_clk_stall_i;
  assign run      = go & ~stall;
  assign terminal = (cnt_q == div_q);

  assign sd_clk_en_o  = run;
  assign sd_clk_o     = sd_clk_q;
  assign rise_strb_o  = rise_q;
  assign fall_strb_o  = fall_q;
  assign burst_busy_o = busy_q;

  // State register; reset clears everything at once, including a high phase in progress.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      div_q       <= '0;
      sd_clk_q    <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      busy_q      <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      sd_clk_q    <= sd_clk_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      busy_q      <= busy_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next-state logic: phase counting, stall stretching of LOW only, divider reload points.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        div_d = div_i;
        if (go) state_d = StLow;
      end
      StLow: begin
        if (!terminal) begin
          cnt_d = cnt_q + DIV_W'(1);
        end else if (run) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else if (!go) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
        // Terminal while stalled: hold the count, stretching the low phase.
      end
      StHigh: begin
        if (!terminal) begin
          cnt_d = cnt_q + DIV_W'(1);
        end else begin
          state_d = StLow;
          cnt_d   = '0;
          div_d   = div_i;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: clock level and edge strobes follow the state transition being taken.
  always_comb begin
    sd_clk_d = (state_d == StHigh);
    rise_d   = (state_q != StHigh) && (state_d == StHigh);
    fall_d   = (state_q == StHigh) && (state_d != StHigh);
  end

  // Burst counter: counts its own rising edges; a new start is only accepted when idle.
  always_comb begin
    busy_d      = busy_q;
    burst_cnt_d = burst_cnt_q;
    if (busy_q) begin
      if (rise_d) begin
        burst_cnt_d = burst_cnt_q - BURST_W'(1);
        if (burst_cnt_q == BURST_W'(1)) busy_d = 1'b0;
      end
    end else if (burst_start_i && (burst_len_i != '0)) begin
      burst_cnt_d = burst_len_i;
      busy_d      = 1'b1;
    end
  end

endmodule

// File: tb/tb_neosd_clk_div.sv
// Scoreboard bench for neosd_clk_div: stimulus pushes hand-computed edge events, a monitor
// pops and compares them whenever a rise or fall strobe appears.
module tb_neosd_clk_div;

  localparam int unsigned DIV_W   = 10;
  localparam int unsigned N_REQ   = 3;
  localparam int unsigned N_STALL = 2;
  localparam int unsigned BURST_W = 8;

  logic               clk_i = 1'b0;
  logic               rstn_i;
  logic [DIV_W-1:0]   div_i;
  logic [N_REQ-1:0]   sd_clk_req_i;
  logic [N_STALL-1:0] sd_clk_stall_i;
  logic               burst_start_i;
  logic [BURST_W-1:0] burst_len_i;
  logic               burst_busy_o;
  logic               sd_clk_en_o;
  logic               rise_strb_o;
  logic               fall_strb_o;
  logic               sd_clk_o;

  neosd_clk_div #(
    .DIV_W  (DIV_W),
    .N_REQ  (N_REQ),
    .N_STALL(N_STALL),
    .BURST_W(BURST_W)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .div_i         (div_i),
    .sd_clk_req_i  (sd_clk_req_i),
    .sd_clk_stall_i(sd_clk_stall_i),
    .burst_start_i (burst_start_i),
    .burst_len_i   (burst_len_i),
    .burst_busy_o  (burst_busy_o),
    .sd_clk_en_o   (sd_clk_en_o),
    .rise_strb_o   (rise_strb_o),
    .fall_strb_o   (fall_strb_o),
    .sd_clk_o      (sd_clk_o)
  );

  always #5 clk_i = ~clk_i;

  // Number of rising clk_i edges so far; read at negedges only.
  int cyc = 0;
  always @(posedge clk_i) cyc++;

  typedef struct packed {
    logic is_rise;
    int   at;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;
  int  n_pass = 0;
  int  n_total = 0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic expect_edge(input logic r, input int at);
    exp_q.push_back('{is_rise: r, at: at});
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  // Wait (bounded) for every expected edge, then watch a while for stray edges.
  task automatic drain(input string name);
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk_i);
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (12) @(negedge clk_i);
    check({name, "_idle_clk"}, int'(sd_clk_o), 0);
  endtask

  // Monitor: every strobe must match the oldest expected edge in kind and time.
  always @(negedge clk_i) begin
    if (rise_strb_o || fall_strb_o) begin
      check("strobe_exclusive", int'(rise_strb_o & fall_strb_o), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_edge_cycle", cyc, -1);
      end else begin
        ev = exp_q.pop_front();
        check("edge_kind_rise", int'(rise_strb_o), int'(ev.is_rise));
        check("edge_cycle", cyc, ev.at);
        check("edge_clk_level", int'(sd_clk_o), int'(ev.is_rise));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected finish", cyc);
    $fatal(1, "timeout");
  end

  int t0;

  initial begin
    rstn_i         = 1'b0;
    div_i          = '0;
    sd_clk_req_i   = '0;
    sd_clk_stall_i = '0;
    burst_start_i  = 1'b0;
    burst_len_i    = '0;
    repeat (3) @(negedge clk_i);
    check("rst_sd_clk", int'(sd_clk_o), 0);
    check("rst_rise", int'(rise_strb_o), 0);
    check("rst_fall", int'(fall_strb_o), 0);
    check("rst_busy", int'(burst_busy_o), 0);
    check("rst_en", int'(sd_clk_en_o), 0);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // div=3, req[0]: first rise 5 cycles after req, then 8-cycle period, 4/4 duty.
    t0 = cyc;
    div_i = 10'd3;
    sd_clk_req_i = 3'b001;
    expect_edge(1'b1, t0 + 5);
    expect_edge(1'b0, t0 + 9);
    expect_edge(1'b1, t0 + 13);
    expect_edge(1'b0, t0 + 17);
    to_cyc(t0 + 2);
    check("t1_en", int'(sd_clk_en_o), 1);
    to_cyc(t0 + 18);
    sd_clk_req_i = '0;
    drain("t1_drain");

    // div=0, req[1]: toggle every cycle; drop req during HIGH -> one fall, then idle.
    t0 = cyc;
    div_i = 10'd0;
    sd_clk_req_i = 3'b010;
    for (int k = 0; k < 3; k++) begin
      expect_edge(1'b1, t0 + 2 + 2 * k);
      expect_edge(1'b0, t0 + 3 + 2 * k);
    end
    to_cyc(t0 + 6);
    sd_clk_req_i = '0;
    drain("t2_drain");

    // div=2, stall[1] for 10 cycles from mid-HIGH: HIGH completes, LOW stretched.
    t0 = cyc;
    div_i = 10'd2;
    sd_clk_req_i = 3'b001;
    expect_edge(1'b1, t0 + 4);
    expect_edge(1'b0, t0 + 7);
    expect_edge(1'b1, t0 + 16);
    expect_edge(1'b0, t0 + 19);
    expect_edge(1'b1, t0 + 22);
    expect_edge(1'b0, t0 + 25);
    to_cyc(t0 + 3);
    check("t3_en_before_stall", int'(sd_clk_en_o), 1);
    to_cyc(t0 + 5);
    sd_clk_stall_i = 2'b10;
    to_cyc(t0 + 8);
    check("t3_en_stalled", int'(sd_clk_en_o), 0);
    check("t3_clk_low_stalled", int'(sd_clk_o), 0);
    to_cyc(t0 + 15);
    sd_clk_stall_i = '0;
    to_cyc(t0 + 22);
    sd_clk_req_i = '0;
    drain("t3_drain");

    // div=1, switch to 4 mid-HIGH: current HIGH stays 2, later phases 5 each.
    t0 = cyc;
    div_i = 10'd1;
    sd_clk_req_i = 3'b100;
    expect_edge(1'b1, t0 + 3);
    expect_edge(1'b0, t0 + 5);
    expect_edge(1'b1, t0 + 10);
    expect_edge(1'b0, t0 + 15);
    to_cyc(t0 + 3);
    div_i = 10'd4;
    to_cyc(t0 + 16);
    sd_clk_req_i = '0;
    drain("t4_drain");

    // Burst of 74 at div=1 with no request; a second start mid-burst is ignored.
    t0 = cyc;
    div_i = 10'd1;
    burst_len_i = 8'd74;
    burst_start_i = 1'b1;
    for (int k = 0; k < 74; k++) begin
      expect_edge(1'b1, t0 + 4 + 4 * k);
      expect_edge(1'b0, t0 + 6 + 4 * k);
    end
    @(negedge clk_i);
    burst_start_i = 1'b0;
    burst_len_i = '0;
    to_cyc(t0 + 3);
    check("t5_busy_start", int'(burst_busy_o), 1);
    to_cyc(t0 + 50);
    burst_len_i = 8'd5;
    burst_start_i = 1'b1;
    @(negedge clk_i);
    burst_start_i = 1'b0;
    burst_len_i = '0;
    to_cyc(t0 + 295);
    check("t5_busy_before_last", int'(burst_busy_o), 1);
    to_cyc(t0 + 296);
    check("t5_busy_at_last_rise", int'(burst_busy_o), 0);
    drain("t5_drain");
    check("t5_busy_end", int'(burst_busy_o), 0);

    // Reset during HIGH with a burst active: everything drops at once, then stays idle.
    t0 = cyc;
    div_i = 10'd1;
    burst_len_i = 8'd10;
    burst_start_i = 1'b1;
    expect_edge(1'b1, t0 + 4);
    @(negedge clk_i);
    burst_start_i = 1'b0;
    burst_len_i = '0;
    to_cyc(t0 + 4);
    #1 rstn_i = 1'b0;
    #1;
    check("t6_rst_clk", int'(sd_clk_o), 0);
    check("t6_rst_rise", int'(rise_strb_o), 0);
    check("t6_rst_fall", int'(fall_strb_o), 0);
    check("t6_rst_busy", int'(burst_busy_o), 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    check("t6_en_after_rst", int'(sd_clk_en_o), 0);
    drain("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/neosd_clk_div.md
Name: neosd_clk_div

Overview:
Parametrised SD clock generator with its own programmable divider. It replaces the fixed external prescaler-tap selection.
- Aggregates clock requests and stalls from any number of CMD/DATA FSMs.
- Stretches the low phase on stall, never emits runt pulses, switches frequency glitch-free, and can emit an autonomous burst of N clocks (card init: 74+ clocks).
- Registered rise/fall strobes drive CMD/DATA sample/launch.

Parameters:
DIV_W, 10, width of divider; half period = div_i+1 clk_i cycles
N_REQ, 3, number of clock-request inputs
N_STALL, 2, number of stall inputs
BURST_W, 8, width of burst clock counter

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
div_i  in  DIV_W  half-period minus one; sampled only at phase boundaries
sd_clk_req_i  in  N_REQ  per-FSM clock request; any set = requested
sd_clk_stall_i  in  N_STALL  per-FSM stall; any set = stalled
burst_start_i  in  1  one-cycle pulse: start burst of burst_len_i clocks
burst_len_i  in  BURST_W  number of rising edges in burst (0 = none)
burst_busy_o  out  1  burst in progress
sd_clk_en_o  out  1  combinational: (|req or burst_busy_o) and not |stall
rise_strb_o  out  1  one-cycle pulse, same cycle sd_clk_o becomes 1
fall_strb_o  out  1  one-cycle pulse, same cycle sd_clk_o becomes 0
sd_clk_o  out  1  SD card clock, registered

Behaviour:
- Reset values:
  - Outputs sd_clk_o=0, rise_strb_o=0, fall_strb_o=0, burst_busy_o=0.
  - Internal state IDLE, cnt=0, div_q=0, burst_cnt=0.
- Internal signals:
  - go = |sd_clk_req_i or burst_busy_o.
  - stall = |sd_clk_stall_i.
  - run = go and not stall.
  - sd_clk_en_o = run.
- FSM states: IDLE, LOW, HIGH. Phase counter cnt is DIV_W bits; terminal when cnt==div_q.
- IDLE:
  - sd_clk_o=0 and cnt=0; div_q<=div_i every cycle.
  - On go: enter LOW with cnt=0, giving a full low half-period before the first rise.
- LOW:
  - cnt increments each cycle until terminal, then holds at terminal.
  - At terminal with run: enter HIGH, sd_clk_o<=1, rise_strb_o<=1, cnt<=0.
  - At terminal with stall: remain LOW, holding cnt (low phase stretched).
  - At terminal with go=0: enter IDLE. Nothing is emitted.
- HIGH:
  - Stall and req changes are ignored; the high phase always completes.
  - At terminal: enter LOW, sd_clk_o<=0, fall_strb_o<=1, cnt<=0, div_q<=div_i (new divider takes effect from this low phase).
- Strobes are high for exactly one clk_i cycle and are never both high.
- div_i=0: sd_clk_o toggles every cycle (clk_i/2) while running; rise and fall strobes alternate each cycle.
- div_i changes mid-phase have no effect until the next LOW entry or IDLE.
- Burst:
  - burst_start_i with burst_len_i!=0 while !burst_busy_o: burst_cnt<=burst_len_i, burst_busy_o<=1.
  - Each rise_strb_o while busy decrements burst_cnt. The decrement to 0 clears burst_busy_o in the same cycle the last rise is emitted; that clock's high phase still completes.
  - burst_start_i while busy is ignored. burst_len_i=0 is ignored.
  - Stall pauses a burst (low phase stretched); edges are not lost.
  - A burst overlapping external requests counts only its own edges but emits shared clocks.
- Reset mid-operation: all state returns to reset values asynchronously; sd_clk_o drops to 0 immediately, so a truncated high phase is permitted only on reset.

Test Plan:
- div_i=3, req[0]=1 held → first rise 5 cycles after req (1 IDLE→LOW + 4 low); then period 8 cycles, duty 4/4; rise/fall strobes coincide with edges.
- div_i=0, req[1]=1 → sd_clk_o toggles every cycle, strobes alternate. Drop req during a HIGH cycle → falls next cycle, then IDLE with sd_clk_o=0.
- div_i=2, running; assert stall[1] during HIGH for 10 cycles → HIGH still lasts 3 cycles, LOW lasts 3+stall overlap. No extra edges; sd_clk_en_o=0 while stalled.
- div_i=1 running; change div_i to 4 mid-HIGH → current HIGH stays 2 cycles; following LOW/HIGH are 5 cycles each, no glitch.
- burst_len_i=74, div_i=1, no req → exactly 74 rise_strb_o pulses. burst_busy_o clears on the 74th rise; sd_clk_o ends low in IDLE. Second start during the burst is ignored.
- Assert rstn_i=0 during HIGH with burst active → sd_clk_o, strobes, burst_busy_o =0 immediately. After release, IDLE until a new req.
